// File: rtl/tohost_pkg.sv
// Shared types and exit-word decoding for the tohost arbiter.
package tohost_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned ExitLsb      = 0;
   localparam int unsigned MaxDataWidth = 128;

   typedef struct packed {
      logic                    is_exit;
      logic [MaxDataWidth-2:0] code;
   } exit_dec_t;

   // A word with the exit bit set ends the program; the remaining upper bits are the code.
   function automatic exit_dec_t exit_decode(input logic [MaxDataWidth-1:0] word);
      exit_dec_t dec;
      dec.is_exit = word[ExitLsb];
      dec.code    = (MaxDataWidth-1)'(word >> (ExitLsb + 1));
      return dec;
   endfunction

endpackage

// File: rtl/tohost_rr_arb.sv
// Combinational round-robin picker: first valid requester at or after ptr wins.
module tohost_rr_arb
   import tohost_pkg::*;
#(
   parameter int unsigned NrCores     = 2,
   parameter int unsigned CoreIdWidth = 1
) (
   input  logic [NrCores-1:0]     valid,
   input  logic [CoreIdWidth-1:0] ptr,
   output logic [NrCores-1:0]     grant,
   output logic [CoreIdWidth-1:0] grant_idx
);

   int unsigned            cand;
   logic [CoreIdWidth-1:0] cand_idx;
   logic                   found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned i = 0; i < NrCores; i++) begin
         cand     = (32'(ptr) + i) % NrCores;
         cand_idx = CoreIdWidth'(cand);
         if (!found && valid[cand_idx]) begin
            found           = 1'b1;
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
         end
      end
   end

endmodule

// File: rtl/tohost_arbiter.sv
// Shares the host tohost channel among NrCores requesters and captures the first exit word.
module tohost_arbiter
   import tohost_pkg::*;
#(
   parameter int unsigned NrCores     = 2,
   parameter int unsigned DataWidth   = 64,
   parameter int unsigned CoreIdWidth = (NrCores > 1) ? $clog2(NrCores) : 1
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NrCores-1:0]                req_valid_i,
   input  logic [NrCores-1:0][DataWidth-1:0] req_data_i,
   output logic [NrCores-1:0]                req_ready_o,
   output logic                              host_valid_o,
   output logic [DataWidth-1:0]              host_data_o,
   output logic [CoreIdWidth-1:0]            host_core_id_o,
   input  logic                              host_ready_i,
   output logic                              exit_valid_o,
   output logic [DataWidth-2:0]              exit_code_o,
   output logic [CoreIdWidth-1:0]            exit_core_id_o
);

   state_e                 state_q;
   logic [CoreIdWidth-1:0] ptr_q;
   logic [CoreIdWidth-1:0] ptr_nxt;
   logic [NrCores-1:0]     grant;
   logic [CoreIdWidth-1:0] grant_idx;
   logic                   grant_valid;
   exit_dec_t              dec;
   logic                   unused_dec;

   tohost_rr_arb #(
      .NrCores     (NrCores),
      .CoreIdWidth (CoreIdWidth)
   ) u_rr_arb (
      .valid     (req_valid_i),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign grant_valid = |grant;
   assign ptr_nxt     = (32'(grant_idx) == NrCores - 1) ? '0 : grant_idx + CoreIdWidth'(1);

   // Ready is gated by reset so it drops immediately when reset asserts.
   assign req_ready_o = (rst_ni && (state_q == IDLE)) ? grant : '0;

   assign dec        = exit_decode(MaxDataWidth'(host_data_o));
   assign unused_dec = ^dec;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= IDLE;
         ptr_q          <= '0;
         host_valid_o   <= 1'b0;
         host_data_o    <= '0;
         host_core_id_o <= '0;
         exit_valid_o   <= 1'b0;
         exit_code_o    <= '0;
         exit_core_id_o <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  host_data_o    <= req_data_i[grant_idx];
                  host_core_id_o <= grant_idx;
                  host_valid_o   <= 1'b1;
                  ptr_q          <= ptr_nxt;
                  state_q        <= BUSY;
               end
            end
            BUSY: begin
               if (host_ready_i) begin
                  host_valid_o <= 1'b0;
                  if (dec.is_exit && !exit_valid_o) begin
                     exit_valid_o   <= 1'b1;
                     exit_code_o    <= dec.code[DataWidth-2:0];
                     exit_core_id_o <= host_core_id_o;
                     state_q        <= DONE;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            DONE: begin
               host_valid_o <= 1'b0;
            end
            default: begin
               host_valid_o <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tohost_arbiter.sv
// Scoreboard bench for tohost_arbiter: expected host words queued at stimulus, checked on handshake.
module tb_tohost_arbiter;

   localparam int unsigned NrCores     = 2;
   localparam int unsigned DataWidth   = 64;
   localparam int unsigned CoreIdWidth = 1;

   typedef struct packed {
      logic [DataWidth-1:0]   data;
      logic [CoreIdWidth-1:0] id;
   } word_t;

   logic                              clk = 1'b0;
   logic                              rst_ni = 1'b0;
   logic [NrCores-1:0]                req_valid_i;
   logic [NrCores-1:0][DataWidth-1:0] req_data_i;
   logic [NrCores-1:0]                req_ready_o;
   logic                              host_valid_o;
   logic [DataWidth-1:0]              host_data_o;
   logic [CoreIdWidth-1:0]            host_core_id_o;
   logic                              host_ready_i;
   logic                              exit_valid_o;
   logic [DataWidth-2:0]              exit_code_o;
   logic [CoreIdWidth-1:0]            exit_core_id_o;

   word_t exp_q[$];
   word_t mon_exp;
   int    n_checks = 0;
   int    n_fail   = 0;

   tohost_arbiter #(
      .NrCores     (NrCores),
      .DataWidth   (DataWidth),
      .CoreIdWidth (CoreIdWidth)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .req_valid_i    (req_valid_i),
      .req_data_i     (req_data_i),
      .req_ready_o    (req_ready_o),
      .host_valid_o   (host_valid_o),
      .host_data_o    (host_data_o),
      .host_core_id_o (host_core_id_o),
      .host_ready_i   (host_ready_i),
      .exit_valid_o   (exit_valid_o),
      .exit_code_o    (exit_code_o),
      .exit_core_id_o (exit_core_id_o)
   );

   always #5 clk = ~clk;

   // Every word the host consumes must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst_ni && host_valid_o && host_ready_i) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL host_word: got data=%h id=%0d, required no word", host_data_o, host_core_id_o);
         end else begin
            mon_exp = exp_q.pop_front();
            if (host_data_o !== mon_exp.data || host_core_id_o !== mon_exp.id) begin
               n_fail++;
               $display("FAIL host_word: got data=%h id=%0d, required data=%h id=%0d",
                        host_data_o, host_core_id_o, mon_exp.data, mon_exp.id);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_ni       = 1'b0;
      req_valid_i  = '0;
      req_data_i   = '0;
      host_ready_i = 1'b0;
      exp_q.delete();
      cyc();
      cyc();
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      rst_ni       = 1'b0;
      req_valid_i  = '1;
      req_data_i   = '1;
      host_ready_i = 1'b1;
      #3;
      n_checks++;
      if (req_ready_o !== '0) begin
         n_fail++;
         $display("FAIL reset_ready: got %b, required 00", req_ready_o);
      end
      cyc();
      n_checks++;
      if ({host_valid_o, host_data_o, host_core_id_o, exit_valid_o, exit_code_o, exit_core_id_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got hv=%b hd=%h hid=%0d ev=%b ec=%h eid=%0d, required all 0",
                  host_valid_o, host_data_o, host_core_id_o, exit_valid_o, exit_code_o, exit_core_id_o);
      end
   endtask

   task automatic test_single();
      do_reset();
      req_valid_i   = 2'b01;
      req_data_i[0] = 64'h10;
      host_ready_i  = 1'b1;
      exp_q.push_back(word_t'{data: 64'h10, id: 1'b0});
      #1;
      n_checks++;
      if (req_ready_o !== 2'b01) begin
         n_fail++;
         $display("FAIL single_grant: got %b, required 01", req_ready_o);
      end
      cyc();
      req_valid_i = '0;
      n_checks++;
      if (host_valid_o !== 1'b1 || host_data_o !== 64'h10 || host_core_id_o !== 1'b0 || req_ready_o !== 2'b00) begin
         n_fail++;
         $display("FAIL single_host: got hv=%b hd=%h id=%0d rdy=%b, required hv=1 hd=10 id=0 rdy=00",
                  host_valid_o, host_data_o, host_core_id_o, req_ready_o);
      end
      cyc();
      req_valid_i = 2'b01;
      #1;
      n_checks++;
      if (host_valid_o !== 1'b0 || exit_valid_o !== 1'b0 || req_ready_o !== 2'b01) begin
         n_fail++;
         $display("FAIL single_idle: got hv=%b ev=%b rdy=%b, required hv=0 ev=0 rdy=01",
                  host_valid_o, exit_valid_o, req_ready_o);
      end
      req_valid_i = '0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL single_drain: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_round_robin();
      logic [NrCores-1:0] exp_rdy;
      do_reset();
      req_valid_i   = 2'b11;
      req_data_i[0] = 64'hA0;
      req_data_i[1] = 64'hB0;
      host_ready_i  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(word_t'{data: 64'hA0, id: 1'b0});
         exp_q.push_back(word_t'{data: 64'hB0, id: 1'b1});
      end
      for (int k = 0; k < 8; k++) begin
         if (k > 0) cyc();
         else #1;
         if (k % 2 == 1)            exp_rdy = 2'b00;
         else if ((k / 2) % 2 == 0) exp_rdy = 2'b01;
         else                       exp_rdy = 2'b10;
         n_checks++;
         if (req_ready_o !== exp_rdy || host_valid_o !== 1'(k % 2)) begin
            n_fail++;
            $display("FAIL rr_step%0d: got rdy=%b hv=%b, required rdy=%b hv=%0d",
                     k, req_ready_o, host_valid_o, exp_rdy, k % 2);
         end
      end
      req_valid_i = '0;
      cyc();
      cyc();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rr_drain: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_exit_stall();
      do_reset();
      req_valid_i   = 2'b10;
      req_data_i[1] = 64'h15;
      host_ready_i  = 1'b0;
      exp_q.push_back(word_t'{data: 64'h15, id: 1'b1});
      #1;
      n_checks++;
      if (req_ready_o !== 2'b10) begin
         n_fail++;
         $display("FAIL stall_grant: got %b, required 10", req_ready_o);
      end
      for (int c = 1; c <= 6; c++) begin
         cyc();
         req_valid_i = '0;
         n_checks++;
         if (host_valid_o !== 1'b1 || host_data_o !== 64'h15 || host_core_id_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got hv=%b hd=%h id=%0d, required hv=1 hd=15 id=1",
                     c, host_valid_o, host_data_o, host_core_id_o);
         end
         if (c == 6) host_ready_i = 1'b1;
      end
      cyc();
      n_checks++;
      if (exit_valid_o !== 1'b1 || exit_code_o !== 63'hA || exit_core_id_o !== 1'b1 || host_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_exit: got ev=%b ec=%h eid=%0d hv=%b, required ev=1 ec=a eid=1 hv=0",
                  exit_valid_o, exit_code_o, exit_core_id_o, host_valid_o);
      end
      req_valid_i   = 2'b11;
      req_data_i[0] = 64'h2;
      req_data_i[1] = 64'h3;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) cyc();
         else #1;
         n_checks++;
         if (req_ready_o !== 2'b00 || host_valid_o !== 1'b0 || exit_valid_o !== 1'b1 ||
             exit_code_o !== 63'hA || exit_core_id_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done%0d: got rdy=%b hv=%b ev=%b ec=%h eid=%0d, required rdy=00 hv=0 ev=1 ec=a eid=1",
                     c, req_ready_o, host_valid_o, exit_valid_o, exit_code_o, exit_core_id_o);
         end
      end
      req_valid_i = '0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL stall_drain: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_success_exit();
      do_reset();
      req_valid_i   = 2'b01;
      req_data_i[0] = 64'h1;
      host_ready_i  = 1'b1;
      exp_q.push_back(word_t'{data: 64'h1, id: 1'b0});
      #1;
      n_checks++;
      if (req_ready_o !== 2'b01) begin
         n_fail++;
         $display("FAIL success_grant: got %b, required 01", req_ready_o);
      end
      cyc();
      req_valid_i = '0;
      cyc();
      n_checks++;
      if (exit_valid_o !== 1'b1 || exit_code_o !== '0 || exit_core_id_o !== 1'b0) begin
         n_fail++;
         $display("FAIL success_exit: got ev=%b ec=%h eid=%0d, required ev=1 ec=0 eid=0",
                  exit_valid_o, exit_code_o, exit_core_id_o);
      end
      req_valid_i   = 2'b10;
      req_data_i[1] = 64'h7;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) cyc();
         else #1;
         n_checks++;
         if (req_ready_o !== 2'b00 || host_valid_o !== 1'b0 || exit_valid_o !== 1'b1 ||
             exit_code_o !== '0 || exit_core_id_o !== 1'b0) begin
            n_fail++;
            $display("FAIL success_stall%0d: got rdy=%b hv=%b ev=%b ec=%h eid=%0d, required rdy=00 hv=0 ev=1 ec=0 eid=0",
                     c, req_ready_o, host_valid_o, exit_valid_o, exit_code_o, exit_core_id_o);
         end
      end
      req_valid_i = '0;
   endtask

   task automatic test_async_reset();
      do_reset();
      req_valid_i   = 2'b01;
      req_data_i[0] = 64'h20;
      host_ready_i  = 1'b0;
      #1;
      cyc();
      req_valid_i = '0;
      n_checks++;
      if (host_valid_o !== 1'b1 || host_data_o !== 64'h20) begin
         n_fail++;
         $display("FAIL areset_busy: got hv=%b hd=%h, required hv=1 hd=20", host_valid_o, host_data_o);
      end
      #3;
      req_valid_i   = 2'b10;
      req_data_i[1] = 64'h33;
      rst_ni        = 1'b0;
      #1;
      n_checks++;
      if ({req_ready_o, host_valid_o, host_data_o, host_core_id_o, exit_valid_o, exit_code_o, exit_core_id_o} !== '0) begin
         n_fail++;
         $display("FAIL areset_clear: got rdy=%b hv=%b hd=%h hid=%0d ev=%b, required all 0",
                  req_ready_o, host_valid_o, host_data_o, host_core_id_o, exit_valid_o);
      end
      #2;
      rst_ni       = 1'b1;
      host_ready_i = 1'b1;
      exp_q.push_back(word_t'{data: 64'h33, id: 1'b1});
      #1;
      n_checks++;
      if (req_ready_o !== 2'b10) begin
         n_fail++;
         $display("FAIL areset_regrant: got %b, required 10", req_ready_o);
      end
      cyc();
      req_valid_i = '0;
      n_checks++;
      if (host_valid_o !== 1'b1 || host_core_id_o !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_host: got hv=%b id=%0d, required hv=1 id=1", host_valid_o, host_core_id_o);
      end
      cyc();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL areset_drain: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_drop_valid();
      do_reset();
      req_valid_i   = 2'b10;
      req_data_i[1] = 64'h40;
      host_ready_i  = 1'b1;
      exp_q.push_back(word_t'{data: 64'h40, id: 1'b1});
      #1;
      n_checks++;
      if (req_ready_o !== 2'b10) begin
         n_fail++;
         $display("FAIL drop_grant1: got %b, required 10", req_ready_o);
      end
      cyc();
      req_valid_i   = 2'b11;
      req_data_i[0] = 64'h50;
      #1;
      n_checks++;
      if (req_ready_o !== 2'b00) begin
         n_fail++;
         $display("FAIL drop_busy: got %b, required 00", req_ready_o);
      end
      cyc();
      req_valid_i = 2'b10;
      exp_q.push_back(word_t'{data: 64'h40, id: 1'b1});
      #1;
      n_checks++;
      if (req_ready_o !== 2'b10) begin
         n_fail++;
         $display("FAIL drop_grant2: got %b, required 10", req_ready_o);
      end
      cyc();
      req_valid_i = '0;
      n_checks++;
      if (host_valid_o !== 1'b1 || host_data_o !== 64'h40 || host_core_id_o !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_host: got hv=%b hd=%h id=%0d, required hv=1 hd=40 id=1",
                  host_valid_o, host_data_o, host_core_id_o);
      end
      cyc();
      cyc();
      n_checks++;
      if (exp_q.size() != 0 || host_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_drain: got %0d pending hv=%b, required 0 pending hv=0", exp_q.size(), host_valid_o);
      end
   endtask

   initial begin
      req_valid_i  = '0;
      req_data_i   = '0;
      host_ready_i = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_exit_stall();
      test_success_exit();
      test_async_reset();
      test_drop_valid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
